// File: rtl/seven_seg_scan_decoder.sv
// Receive side of a multiplexed seven-segment bus: waits for a stable digit pattern and decodes it back to BCD.
// Optional macro SEG_ALT_GLYPH_EN accepts the tailed 6 and 9 glyphs as legal.
module seven_seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  update,
  output logic [1:0]            upd_digit,
  output logic                  err
);

  localparam logic [CNT_W-1:0] STAB      = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef struct packed {
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
  } sample_t;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] val;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] s);
    dec_t d;
    d = '{legal: 1'b1, blank: 1'b0, val: 4'd0};
    case (s)
      7'b0111111: d.val = 4'd0;
      7'b0000110: d.val = 4'd1;
      7'b1011011: d.val = 4'd2;
      7'b1001111: d.val = 4'd3;
      7'b1100110: d.val = 4'd4;
      7'b1101101: d.val = 4'd5;
      7'b1111100: d.val = 4'd6;
      7'b0000111: d.val = 4'd7;
      7'b1111111: d.val = 4'd8;
      7'b1100111: d.val = 4'd9;
`ifdef SEG_ALT_GLYPH_EN
      7'b1111101: d.val = 4'd6;
      7'b1101111: d.val = 4'd9;
`endif
      7'b0000000: begin d.legal = 1'b0; d.blank = 1'b1; end
      default:    d.legal = 1'b0;
    endcase
    return d;
  endfunction

  sample_t                s_q, in_w;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   committed_q;
  logic [DIGITS-1:0][3:0] bcd_q;
  logic [DIGITS-1:0]      valid_q;
  logic                   update_q, err_q, err_d;
  logic [1:0]             upd_digit_q, sel_idx;
  logic                   same, sel_ok, commit;
  int                     nzero;
  dec_t                   dec;

  assign in_w = '{an: an_in, seg: seg_in};
  assign same = (in_w == s_q);
  assign dec  = decode(s_q.seg);

  // Exactly one low anode selects a digit; anything else is a scan transition.
  always_comb begin
    nzero   = 0;
    sel_idx = 2'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!s_q.an[i]) begin
        nzero   = nzero + 1;
        sel_idx = 2'(i);
      end
    end
    sel_ok = (nzero == 1);
  end

  assign commit = same && (cnt_q == STAB_LAST) && sel_ok && !committed_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!same)            cnt_d = '0;
    else if (cnt_q < STAB) cnt_d = cnt_q + 1'b1;
    err_d = err_q;
    if (commit && !dec.legal && !dec.blank) err_d = 1'b1;
    else if (err_clr)                       err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q         <= '0;
      cnt_q       <= '0;
      committed_q <= 1'b0;
      bcd_q       <= '0;
      valid_q     <= '0;
      update_q    <= 1'b0;
      upd_digit_q <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      s_q      <= in_w;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      update_q <= commit;
      if (!same) committed_q <= 1'b0;
      else if (commit) committed_q <= 1'b1;
      if (commit) begin
        upd_digit_q <= sel_idx;
        for (int i = 0; i < DIGITS; i++) begin
          if (!s_q.an[i]) begin
            valid_q[i] <= dec.legal;
            if (dec.legal) bcd_q[i] <= dec.val;
          end
        end
      end
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_valid = valid_q;
  assign update      = update_q;
  assign upd_digit   = upd_digit_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboarded directed test: stimulus pushes expected commits, a monitor checks each update pulse.
module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic        err_clr;
  logic [15:0] bcd_out;
  logic [3:0]  digit_valid;
  logic        update;
  logic [1:0]  upd_digit;
  logic        err;

  seven_seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .an_in(an_in), .err_clr(err_clr),
    .bcd_out(bcd_out), .digit_valid(digit_valid), .update(update),
    .upd_digit(upd_digit), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         dig;
    logic       vld;
    logic [3:0] bcd;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input int d, input logic v, input logic [3:0] b, input logic e);
    exp_t x;
    x.dig = d; x.vld = v; x.bcd = b; x.e = e;
    exp_q.push_back(x);
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an_in  = a;
    seg_in = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t x;
    forever begin
      @(negedge clk);
      if (update === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_update", 32'(upd_digit), 32'hFFFF);
        end else begin
          x = exp_q.pop_front();
          chk("upd_digit", 32'(upd_digit), 32'(x.dig));
          chk("digit_valid_bit", 32'(digit_valid[x.dig]), 32'(x.vld));
          chk("bcd_nibble", 32'(bcd_out[x.dig*4 +: 4]), 32'(x.bcd));
          chk("err_at_update", 32'(err), 32'(x.e));
        end
      end
    end
  endtask

  initial begin
    int wait_cyc;
    reset = 1'b1; an_in = 4'hF; seg_in = 7'd0; err_clr = 1'b0;
    fork monitor(); join_none
    #12;
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_update", 32'(update), 32'h0);
    chk("rst_upd_digit", 32'(upd_digit), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    reset = 1'b0;
    hold(4'hF, 7'd0, 3);

    // Stable commit of 3 on digit 0, then long hold with no repeat
    push(0, 1'b1, 4'd3, 1'b0);
    hold(4'hE, 7'b1001111, 5);
    hold(4'hE, 7'b1001111, 10);
    chk("t1_bcd0", 32'(bcd_out[3:0]), 32'd3);

    // Glitch rejection on digit 1
    hold(4'hD, 7'b1101101, 3);
    push(1, 1'b1, 4'd1, 1'b0);
    hold(4'hD, 7'b0000110, 5);

    // Full scan 2,0,4,9
    push(0, 1'b1, 4'd2, 1'b0); hold(4'hE, 7'b1011011, 6);
    push(1, 1'b1, 4'd0, 1'b0); hold(4'hD, 7'b0111111, 6);
    push(2, 1'b1, 4'd4, 1'b0); hold(4'hB, 7'b1100110, 6);
    push(3, 1'b1, 4'd9, 1'b0); hold(4'h7, 7'b1100111, 6);
    chk("scan_bcd", 32'(bcd_out), 32'h9402);
    chk("scan_valid", 32'(digit_valid), 32'hF);

    // Illegal pattern, then err_clr coincident with a second illegal commit
    push(2, 1'b0, 4'd4, 1'b1); hold(4'hB, 7'b0101010, 5);
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_valid", 32'(digit_valid), 32'hB);
    hold(4'hF, 7'b0101010, 2);
    push(2, 1'b0, 4'd4, 1'b1); hold(4'hB, 7'b0101010, 4);
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    chk("clr_vs_set_err", 32'(err), 32'h1);
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    chk("clr_alone_err", 32'(err), 32'h0);

    // Blank commit, then identical re-commits
    push(0, 1'b0, 4'd2, 1'b0); hold(4'hE, 7'b0000000, 5);
    chk("blank_valid", 32'(digit_valid), 32'hA);
    chk("blank_err", 32'(err), 32'h0);
    push(0, 1'b1, 4'd2, 1'b0); hold(4'hE, 7'b1011011, 5);
    hold(4'hF, 7'b1011011, 2);
    push(0, 1'b1, 4'd2, 1'b0); hold(4'hE, 7'b1011011, 5);

    // Two anodes low: never commits
    hold(4'hC, 7'b1111111, 8);
    chk("multi_bcd", 32'(bcd_out), 32'h9402);

    // Alternate 6 / 9 glyphs
`ifdef SEG_ALT_GLYPH_EN
    push(0, 1'b1, 4'd6, 1'b0); hold(4'hE, 7'b1111101, 5);
    push(1, 1'b1, 4'd9, 1'b0); hold(4'hD, 7'b1101111, 5);
`else
    push(0, 1'b0, 4'd2, 1'b1); hold(4'hE, 7'b1111101, 5);
    push(1, 1'b0, 4'd0, 1'b1); hold(4'hD, 7'b1101111, 5);
`endif

    // Set err and make every digit valid before the mid-window reset
    push(3, 1'b0, 4'd9, 1'b1); hold(4'h7, 7'b0000001, 5);
    push(3, 1'b1, 4'd9, 1'b1); hold(4'h7, 7'b1100111, 5);
    push(0, 1'b1, 4'd2, 1'b1); hold(4'hE, 7'b1011011, 5);
    push(1, 1'b1, 4'd1, 1'b1); hold(4'hD, 7'b0000110, 5);
    push(2, 1'b1, 4'd4, 1'b1); hold(4'hB, 7'b1100110, 5);
    chk("pre_rst_valid", 32'(digit_valid), 32'hF);
    chk("pre_rst_err", 32'(err), 32'h1);
    chk("pre_rst_bcd", 32'(bcd_out), 32'h9412);

    // Async reset in the middle of a stable window
    hold(4'hD, 7'b1001111, 3);
    #2 reset = 1'b1;
    #1;
    chk("async_bcd", 32'(bcd_out), 32'h0);
    chk("async_valid", 32'(digit_valid), 32'h0);
    chk("async_err", 32'(err), 32'h0);
    chk("async_update", 32'(update), 32'h0);
    chk("async_upd_digit", 32'(upd_digit), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    push(1, 1'b1, 4'd3, 1'b0); hold(4'hD, 7'b1001111, 5);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    chk("pending_updates", 32'(exp_q.size()), 32'h0);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
Receive-side counterpart of the BCD-to-seven-segment display driver. Samples a multiplexed seven-segment bus (segment lines plus active-low digit anodes). For each scanned digit it waits for a stable pattern, decodes it back to a 4-bit BCD value, and holds the result in a per-digit register. Used as a display loopback checker and to read back scanned display data into lab datapaths.

Parameters:
DIGITS, 4, number of multiplexed digit positions (anodes).
STABLE_CYCLES, 4, consecutive identical samples required before a pattern is committed (>=2).
CNT_W, 3, stability counter width; must hold STABLE_CYCLES.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
seg_in  input  7  segment lines [7:1]; bit1=a … bit7=g; active-high
an_in  input  DIGITS  anode enables; active-low; exactly one low selects a digit
err_clr  input  1  clears the sticky err flag
bcd_out  output  4*DIGITS  decoded BCD; digit i at [4i+3:4i]
digit_valid  output  DIGITS  1 = digit i holds a valid decoded value
update  output  1  one-cycle pulse on every commit
upd_digit  output  2  index of the digit committed with the current update (sized for DIGITS<=4)
err  output  1  sticky flag: illegal segment pattern committed

Behaviour:
- Reset (async, active-high): bcd_out=0, digit_valid=0, update=0, upd_digit=0, err=0, sample register=0, counter=0, committed flag=0.
- Sample stage: each rising edge registers {an_in, seg_in} into s_reg.
- Stability counter:
  - Incoming {an_in, seg_in} differs from s_reg: cnt<=0, committed<=0.
  - Equal, and cnt<STABLE_CYCLES: cnt increments.
  - Counter saturates at STABLE_CYCLES.
- Commit condition: incoming equals s_reg, cnt==STABLE_CYCLES-1, and s_reg anode field has exactly one zero bit.
  - Inputs must be held across STABLE_CYCLES+1 consecutive edges.
  - update is high for the cycle after that edge; only one commit per stable window.
- Anode field with zero or multiple low bits: never commits. The counter still runs; outputs are untouched.
- Decode table, exact patterns on seg[7:1]:
  - 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4
  - 1101101=5, 1111100=6, 0000111=7, 1111111=8, 1100111=9
- Commit with a legal pattern: bcd for digit i <= value, digit_valid[i]<=1, update<=1, upd_digit<=i.
- Commit with 0000000 (blank): digit_valid[i]<=0, bcd unchanged, update<=1, err unchanged.
- Commit with any other pattern: digit_valid[i]<=0, bcd unchanged, update<=1, err<=1.
- err_clr: clears err on the next edge. If a new error commit occurs on the same edge as err_clr, set wins (err stays 1).
- Re-commit of an identical value after the inputs change and return: still pulses update.
- Reset asserted mid-window: counter and all outputs return to reset values immediately; no partial commit.

Optional Feature:
Macro SEG_ALT_GLYPH_EN.
- Defined: additionally accept 1111101 as 6 and 1101111 as 9, both legal with no err.
- Undefined: those two patterns are illegal and set err.

Test Plan:
- Reset: assert reset mid-operation with err=1 and digit_valid=1111 -> all outputs 0 asynchronously, before the next edge.
- Stable commit: an_in=1110, seg_in=1001111 held 5 edges -> update pulses once with upd_digit=0; bcd_out[3:0]=3; digit_valid[0]=1. Holding 10 more edges gives no further pulse.
- Glitch rejection: an_in=1101 with seg 1101101 held for 3 edges, then seg changes to 0000110 and is held 5 edges -> single commit, digit 1 = 1 (never 5).
- Full scan: rotate anodes 1110/1101/1011/0111 with digits 2,0,4,9, each held 6 edges -> bcd_out=16'h9402, digit_valid=1111, 4 update pulses.
- Illegal pattern and clear: seg 0101010 on an_in=1011 for 5 edges -> err=1, digit_valid[2]=0. Then err_clr coincident with a second illegal commit -> err stays 1; err_clr alone -> err=0.
- Multi-anode / optional glyph: an_in=1100 with legal seg held 8 edges -> no update. seg 1111101 on an_in=1110 -> macro defined: bcd 6, err 0; macro undefined: err=1.
